alu_result_tx: RTL and testbench

- Response-side packetizer for the UART ALU; the outbound counterpart to the operand path that feeds the ALU.
- Captures one ALU result (opcode, up to 64-bit data, byte count) and serializes it as a framed byte stream to the UART transmitter.
- Transmitter interface is a byte-wide valid/ready handshake.
- Frame layout matches the inbound packet format: opcode, reserved 0x00, length LSB, length MSB, then data bytes LSB-first.

---
 rtl/alu_result_tx.sv | 139 +++++++++++++
 tb/tb_alu_result_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_tx.sv
// Response packetizer: frames one ALU result as opcode, 0x00, length LSB/MSB, then payload LSB-first.
// Optional ALU_TX_CHECKSUM_EN appends an XOR checksum byte covering every preceding frame byte.
module alu_result_tx #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             opcode_i,
  input  logic [8*MAX_BYTES-1:0] data_i,
  input  logic [3:0]             nbytes_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int HDR_BYTES = 4;

`ifdef ALU_TX_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`endif

  state_t                 state, state_nxt;
  logic [7:0]             opcode_r;
  logic [8*MAX_BYTES-1:0] data_r;
  logic [3:0]             n_r;
  logic [3:0]             idx;
  logic [15:0]            len;
  logic [7:0]             data_byte;
  logic                   accept;
  logic                   hs;
  logic                   fin;
`ifdef ALU_TX_CHECKSUM_EN
  logic [7:0]             csum_r;
`endif

  function automatic logic [3:0] clamp_count(input logic [3:0] n);
    if (int'(n) > MAX_BYTES) return 4'(MAX_BYTES);
    return n;
  endfunction

  assign ready_o    = (state == S_IDLE);
  assign busy_o     = ~ready_o;
  assign tx_valid_o = ~ready_o;
  assign accept     = ready_o & valid_i;
  assign hs         = tx_valid_o & tx_ready_i;
  assign data_byte  = 8'(data_r >> {idx, 3'b000});

`ifdef ALU_TX_CHECKSUM_EN
  assign len = 16'(HDR_BYTES) + 16'(n_r) + 16'd1;
`else
  assign len = 16'(HDR_BYTES) + 16'(n_r);
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; fin marks the handshake of the last payload/header byte
  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    case (state)
      S_IDLE: if (valid_i) state_nxt = S_HDR;
      S_HDR: begin
        if (hs && idx == 4'd3) begin
          if (n_r != 4'd0) state_nxt = S_DATA;
          else             fin = 1'b1;
        end
      end
      S_DATA: if (hs && idx == n_r - 4'd1) fin = 1'b1;
`ifdef ALU_TX_CHECKSUM_EN
      S_CSUM: if (hs) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
`ifdef ALU_TX_CHECKSUM_EN
    if (fin) state_nxt = S_CSUM;
`else
    if (fin) state_nxt = S_IDLE;
`endif
  end

  // capture and byte-index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_r <= 8'h00;
      data_r   <= '0;
      n_r      <= 4'd0;
      idx      <= 4'd0;
`ifdef ALU_TX_CHECKSUM_EN
      csum_r   <= 8'h00;
`endif
    end else if (accept) begin
      opcode_r <= opcode_i;
      data_r   <= data_i;
      n_r      <= clamp_count(nbytes_i);
      idx      <= 4'd0;
`ifdef ALU_TX_CHECKSUM_EN
      csum_r   <= 8'h00;
`endif
    end else begin
      if (state_nxt != state) idx <= 4'd0;
      else if (hs)            idx <= idx + 4'd1;
`ifdef ALU_TX_CHECKSUM_EN
      if (hs) csum_r <= csum_r ^ tx_data_o;
`endif
    end
  end

  // output decode
  always_comb begin
    tx_data_o = 8'h00;
    done_o    = hs && (state != S_IDLE) && (state_nxt == S_IDLE);
    case (state)
      S_HDR: begin
        case (idx[1:0])
          2'd0:    tx_data_o = opcode_r;
          2'd1:    tx_data_o = 8'h00;
          2'd2:    tx_data_o = len[7:0];
          default: tx_data_o = len[15:8];
        endcase
      end
      S_DATA: tx_data_o = data_byte;
`ifdef ALU_TX_CHECKSUM_EN
      S_CSUM: tx_data_o = csum_r;
`endif
      default: tx_data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: frame contents, backpressure, clamping, busy/accept and mid-frame reset.
module tb_alu_result_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  opcode_i;
  logic [63:0] data_i;
  logic [3:0]  nbytes_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  alu_result_tx #(.MAX_BYTES(8)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .data_i(data_i), .nbytes_i(nbytes_i),
    .valid_i(valid_i), .ready_o(ready_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The checksum build lengthens the frame by one and appends the XOR of all prior bytes.
  task automatic finalize();
`ifdef ALU_TX_CHECKSUM_EN
    logic [7:0] x;
    exp_q[2] = exp_q[2] + 8'd1;
    x = 8'h00;
    foreach (exp_q[k]) x = x ^ exp_q[k];
    exp_q.push_back(x);
`endif
  endtask

  // Entered on the falling edge just after accept; walks every byte of exp_q.
  task automatic run_frame(input string tag, input int stall_at, input int stall_n, input int poke_at);
    int last;
    finalize();
    last = exp_q.size() - 1;
    chk({tag, " busy"}, 16'(busy_o), 16'd1);
    for (int i = 0; i <= last; i++) begin
      if (i == stall_at) begin
        tx_ready_i = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk({tag, " stall valid"}, 16'(tx_valid_o), 16'd1);
          chk({tag, " stall data"}, 16'(tx_data_o), 16'(exp_q[i]));
          chk({tag, " stall done"}, 16'(done_o), 16'd0);
          @(negedge clk);
        end
        tx_ready_i = 1'b1;
      end
      chk($sformatf("%s valid[%0d]", tag, i), 16'(tx_valid_o), 16'd1);
      chk($sformatf("%s byte[%0d]", tag, i), 16'(tx_data_o), 16'(exp_q[i]));
      chk($sformatf("%s done[%0d]", tag, i), 16'(done_o), 16'(i == last));
      if (i == poke_at) begin
        valid_i  = 1'b1;
        opcode_i = 8'hFF;
        data_i   = '1;
        nbytes_i = 4'd15;
      end
      @(negedge clk);
      if (i == poke_at) valid_i = 1'b0;
    end
    chk({tag, " ready after"}, 16'(ready_o), 16'd1);
    chk({tag, " idle valid"}, 16'(tx_valid_o), 16'd0);
    chk({tag, " done low"}, 16'(done_o), 16'd0);
  endtask

  task automatic start(input logic [7:0] opc, input logic [63:0] d, input logic [3:0] n);
    opcode_i = opc;
    data_i   = d;
    nbytes_i = n;
    valid_i  = 1'b1;
    @(negedge clk);
    valid_i  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    valid_i    = 1'b0;
    tx_ready_i = 1'b1;
    opcode_i   = 8'h00;
    data_i     = '0;
    nbytes_i   = 4'd0;
    @(negedge clk);
    chk("rst ready", 16'(ready_o), 16'd1);
    chk("rst busy", 16'(busy_o), 16'd0);
    chk("rst tx_valid", 16'(tx_valid_o), 16'd0);
    chk("rst tx_data", 16'(tx_data_o), 16'h00);
    chk("rst done", 16'(done_o), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic frame
    start(8'hEC, 64'h44332211, 4'd4);
    exp_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("basic", -1, 0, -1);

    // backpressure while the length byte is presented
    start(8'hEC, 64'h44332211, 4'd4);
    exp_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("stall", 2, 3, -1);

    // header-only frame
    start(8'hAD, 64'h0, 4'd0);
    exp_q = '{8'hAD, 8'h00, 8'h04, 8'h00};
    run_frame("empty", -1, 0, -1);

    // oversize count clamps to 8
    start(8'hAC, 64'h8877665544332211, 4'd12);
    exp_q = '{8'hAC, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88};
    run_frame("clamp", -1, 0, -1);

    // valid_i pulsed mid-frame with new inputs is ignored
    start(8'h3C, 64'hBEEF, 4'd2);
    exp_q = '{8'h3C, 8'h00, 8'h06, 8'h00, 8'hEF, 8'hBE};
    run_frame("poke", -1, 0, 3);

    // back-to-back with valid_i held high
    opcode_i = 8'h11; data_i = 64'h5A; nbytes_i = 4'd1; valid_i = 1'b1;
    @(negedge clk);
    opcode_i = 8'h22; data_i = 64'h77;
    exp_q = '{8'h11, 8'h00, 8'h05, 8'h00, 8'h5A};
    run_frame("b2b first", -1, 0, -1);
    @(negedge clk);
    valid_i = 1'b0;
    exp_q = '{8'h22, 8'h00, 8'h05, 8'h00, 8'h77};
    run_frame("b2b second", -1, 0, -1);

    // reset during the fifth byte
    start(8'hEC, 64'h44332211, 4'd4);
    repeat (4) @(negedge clk);
    chk("rst mid byte5", 16'(tx_data_o), 16'h11);
    #2 rst = 1'b1;
    #1;
    chk("rst mid tx_valid", 16'(tx_valid_o), 16'd0);
    chk("rst mid ready", 16'(ready_o), 16'd1);
    chk("rst mid busy", 16'(busy_o), 16'd0);
    chk("rst mid tx_data", 16'(tx_data_o), 16'h00);
    chk("rst mid done", 16'(done_o), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst tx_valid", 16'(tx_valid_o), 16'd0);
    chk("post rst ready", 16'(ready_o), 16'd1);
    start(8'hAD, 64'h0, 4'd0);
    exp_q = '{8'hAD, 8'h00, 8'h04, 8'h00};
    run_frame("after rst", -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
